mult_sequencer: RTL and testbench

//  Control FSM and operand registers for the 8-bit signed add-shift multiplier.

---
 rtl/mult_pkg.sv | 6 +
 rtl/sign_extend_adder.sv | 13 +
 rtl/mult_sequencer.sv | 100 ++++++++++
 tb/tb_mult_sequencer.sv | 114 +++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the 8-bit signed add-shift multiplier.
package mult_pkg;
    localparam int WIDTH  = 8;
    localparam int N_PASS = 8;
    typedef enum logic [2:0] {IDLE, CLR, ADD, SHIFT, HOLD} state_t;
endpackage

// File: rtl/sign_extend_adder.sv
// sign_extend_adder: 9-bit sign-extended add (fn=0) or subtract (fn=1) of two 8-bit operands.
module sign_extend_adder
    import mult_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             fn,
    output logic [WIDTH:0]   s
);
    logic [WIDTH:0] b_x;
    assign b_x = {(WIDTH+1){fn}} ^ {b[WIDTH-1], b};
    assign s   = {a[WIDTH-1], a} + b_x + {{WIDTH{1'b0}}, fn};
endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: FSM, pass counter and A/B/X registers for the signed add-shift multiplier.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter bit CLEAR_ON_RUN = 1'b1
)
(
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             Busy,
    output logic             Done
);
    localparam int CW = $clog2(N_PASS);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             x_q, x_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_pass;
    logic [WIDTH:0]   sum;
    // The final pass handles the multiplier sign bit, whose weight is negative.
    assign last_pass = cnt_q == CW'(N_PASS - 1);
    sign_extend_adder u_adder (
        .a  (a_q),
        .b  (S),
        .fn (last_pass),
        .s  (sum)
    );
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_q   <= '0;
            b_q   <= '0;
            x_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            x_q   <= x_d;
            cnt_q <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ClearA_LoadB ? IDLE : Run ? (CLEAR_ON_RUN ? CLR : ADD) : IDLE;
            CLR:     state_d = ADD;
            ADD:     state_d = SHIFT;
            SHIFT:   state_d = last_pass ? HOLD : ADD;
            HOLD:    state_d = Run ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        x_d   = x_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: begin
                if (ClearA_LoadB) begin
                    a_d = '0;
                    x_d = 1'b0;
                    b_d = S;
                end else if (Run) begin
                    cnt_d = '0;
                end
            end
            CLR: begin
                a_d   = '0;
                x_d   = 1'b0;
                cnt_d = '0;
            end
            ADD: begin
                if (b_q[0]) {x_d, a_d} = sum;
            end
            SHIFT: begin
                a_d   = {x_q, a_q[WIDTH-1:1]};
                b_d   = {a_q[0], b_q[WIDTH-1:1]};
                cnt_d = last_pass ? cnt_q : cnt_q + 1'b1;
            end
            default: ;
        endcase
    end
    always_comb begin
        Busy = state_q inside {CLR, ADD, SHIFT};
        Done = state_q == HOLD;
    end
    assign Aval = a_q;
    assign Bval = b_q;
    assign X    = x_q;
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: scoreboard bench for mult_sequencer with directed multiply vectors.
module tb_mult_sequencer;
    logic       Clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic       Run = 1'b0;
    logic       ClearA_LoadB = 1'b0;
    logic [7:0] S = 8'h00;
    logic [7:0] Aval, Bval;
    logic       X, Busy, Done;
    int         checks = 0;
    int         errors = 0;
    logic [16:0] exp_q[$];
    logic       done_d = 1'b0;
    mult_sequencer dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .S            (S),
        .Aval         (Aval),
        .Bval         (Bval),
        .X            (X),
        .Busy         (Busy),
        .Done         (Done)
    );
    always #5 Clk = ~Clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    // Monitor: each rising Done presents one product {Aval,Bval,X}.
    always @(negedge Clk) begin
        if (Done && !done_d) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got {A,B,X}=0x%0h with no expected product", {Aval, Bval, X});
            end else begin
                chk("product", {15'd0, Aval, Bval, X}, {15'd0, exp_q.pop_front()});
            end
        end
        done_d = Done;
    end
    task automatic do_mult(input string name, input logic [7:0] b, input logic [7:0] s,
                           input logic [16:0] exp, input int hold, input bit pulse);
        int n;
        logic [16:0] snap;
        S = b;
        ClearA_LoadB = 1'b1;
        @(posedge Clk);
        #1 ClearA_LoadB = 1'b0;
        chk({name, "_loadB"}, {24'd0, Bval}, {24'd0, b});
        S = s;
        exp_q.push_back(exp);
        Run = 1'b1;
        n = 0;
        do begin
            @(posedge Clk);
            n++;
            #1;
            if (pulse && n == 5) ClearA_LoadB = 1'b1;
            if (pulse && n == 6) ClearA_LoadB = 1'b0;
        end while (!Done && n < 40);
        chk({name, "_latency"}, n, 18);
        snap = {Aval, Bval, X};
        for (int i = 0; i < hold; i++) begin
            @(posedge Clk);
            #1;
            chk({name, "_hold"}, {14'd0, Done, Busy, Aval, Bval, X}, {14'd0, 1'b1, 1'b0, snap});
        end
        Run = 1'b0;
        @(posedge Clk);
        #1 chk({name, "_idle"}, {30'd0, Busy, Done}, 32'd0);
    endtask
    initial begin
        #1 Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1 chk("reset_state", {13'd0, Aval, Bval, X, Busy, Done}, 32'd0);
        #2 Reset_n = 1'b1;
        S = 8'hFF;
        ClearA_LoadB = 1'b1;
        @(posedge Clk);
        #1 ClearA_LoadB = 1'b0;
        S = 8'h7F;
        Run = 1'b1;
        repeat (10) @(posedge Clk);
        #3 chk("busy_mid_multiply", {31'd0, Busy}, 32'd1);
        Reset_n = 1'b0;
        #1 chk("reset_mid_multiply", {13'd0, Aval, Bval, X, Busy, Done}, 32'd0);
        Run = 1'b0;
        #2 Reset_n = 1'b1;
        repeat (3) @(posedge Clk);
        #1 chk("idle_after_reset", {13'd0, Aval, Bval, X, Busy, Done}, 32'd0);
        do_mult("t2_3x5", 8'h03, 8'h05, {16'h000F, 1'b0}, 0, 1'b0);
        do_mult("t3_m7x59", 8'hF9, 8'h3B, {16'hFE63, 1'b1}, 0, 1'b0);
        do_mult("t4_m128sq", 8'h80, 8'h80, {16'h4000, 1'b0}, 50, 1'b1);
        S = 8'h22;
        Run = 1'b1;
        ClearA_LoadB = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1 chk("t6_load_priority", {15'd0, Aval, Bval, Busy}, {15'd0, 8'h00, 8'h22, 1'b0});
        end
        Run = 1'b0;
        ClearA_LoadB = 1'b0;
        repeat (2) @(posedge Clk);
        #1 chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
